// File: rtl/sprite_seq_pkg.sv
// Shared definitions for the sprite animation sequencer.
//   seq_state_e   : FSM state encoding
//   MODE_LOOP     : Mode_Sig value selecting wrap-around playback
//   MODE_PINGPONG : Mode_Sig value selecting bounce playback
//   DIR_UP/DOWN   : ping-pong travel direction
package sprite_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  localparam logic MODE_LOOP     = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler.
//   CLK    : clock
//   RSTn   : asynchronous active-low reset
//   enable : counter runs while high, held at 0 while low
//   tick   : single-cycle pulse every TICK_DIV+1 enabled cycles
// Because the count is cleared whenever enable is low, the first tick after
// enable rises always lands on the (TICK_DIV+1)-th enabled cycle.
module ms_tick_gen #(
  parameter int TICK_DIV = 39999,
  localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite animation sequencer: copies one frame at a time from a sprite ROM
// into a frame buffer, then holds it for Delay_Ms milliseconds before
// moving on to the next frame.
//   CLK, RSTn       : clock, asynchronous active-low reset
//   Start_Sig       : level, starts playback at frame 0 when idle
//   Stop_Sig        : level, stops at the next frame boundary
//   Mode_Sig        : 0 = loop, 1 = ping-pong
//   Delay_Ms        : per-frame hold time in ms, sampled on HOLD entry
//   Rom_Addr/Data   : synchronous ROM port, data one cycle after address
//   Write_En_Sig, Write_Addr_Sig, Write_Data : frame-buffer write port
//   Frame_Idx       : frame currently loaded/displayed
//   Busy_Sig        : high outside IDLE
//   Frame_Done_Sig  : pulse alongside the last row write of a frame
// Build option: define SPRITE_SEQ_PINGPONG_EN to enable ping-pong playback;
// without it Mode_Sig is ignored and playback always loops.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped, waiting for Start_Sig with Stop_Sig low
// LOAD  | presenting ROM addresses for rows 0..ROWS-1, one per cycle
// DRAIN | last row's ROM data being written; Frame_Done_Sig pulses
// HOLD  | counting Delay_Ms ticks, then stop or advance to next frame
module sprite_anim_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int FRAMES   = 6,
  parameter int ROWS     = 16,
  parameter int ROW_W    = 16,
  parameter int TICK_DIV = 39999,
  parameter int DELAY_W  = 10,
  localparam int ADDR_W  = $clog2(FRAMES * ROWS),
  localparam int ROW_AW  = $clog2(ROWS),
  localparam int FIDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Start_Sig,
  input  logic               Stop_Sig,
  input  logic               Mode_Sig,
  input  logic [DELAY_W-1:0] Delay_Ms,
  output logic [ADDR_W-1:0]  Rom_Addr,
  input  logic [ROW_W-1:0]   Rom_Data,
  output logic               Write_En_Sig,
  output logic [ROW_AW-1:0]  Write_Addr_Sig,
  output logic [ROW_W-1:0]   Write_Data,
  output logic [FIDX_W-1:0]  Frame_Idx,
  output logic               Busy_Sig,
  output logic               Frame_Done_Sig
);

  localparam logic [ROW_AW-1:0] LAST_ROW   = ROW_AW'(ROWS - 1);
  localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(FRAMES - 1);

  seq_state_e         state_q, state_d;
  logic [ROW_AW-1:0]  row_q, row_d;
  logic [FIDX_W-1:0]  frame_q, frame_d;
  logic [DELAY_W-1:0] hold_q, hold_d;
  logic               we_q, we_d;
  logic [ROW_AW-1:0]  wa_q, wa_d;
  logic               done_q, done_d;
  logic               hold_en;
  logic               ms_tick;
  logic               hold_exit;
  logic [FIDX_W-1:0]  next_frame;

`ifdef SPRITE_SEQ_PINGPONG_EN
  logic dir_q, dir_d, next_dir;
`else
  // Mode_Sig has no effect in loop-only builds.
  logic unused_mode;
  assign unused_mode = Mode_Sig;
`endif

  assign hold_en = (state_q == ST_HOLD);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .enable (hold_en),
    .tick   (ms_tick)
  );

  // ROWS is a power of two, so frame*ROWS+row is a plain concatenation.
  assign Rom_Addr       = ADDR_W'({frame_q, row_q});
  assign Write_En_Sig   = we_q;
  assign Write_Addr_Sig = wa_q;
  // ROM data arrives one cycle after its address, aligned with we_q.
  assign Write_Data     = we_q ? Rom_Data : '0;
  assign Frame_Idx      = frame_q;
  assign Busy_Sig       = (state_q != ST_IDLE);
  assign Frame_Done_Sig = done_q;

  always_comb begin
    next_frame = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
`ifdef SPRITE_SEQ_PINGPONG_EN
    next_dir = DIR_UP;
    if ((Mode_Sig == MODE_PINGPONG) && (FRAMES > 1)) begin
      next_dir = dir_q;
      if (dir_q == DIR_UP) begin
        if (frame_q == LAST_FRAME) begin
          next_frame = frame_q - 1'b1;
          next_dir   = DIR_DOWN;
        end else begin
          next_frame = frame_q + 1'b1;
        end
      end else begin
        if (frame_q == '0) begin
          next_frame = frame_q + 1'b1;
          next_dir   = DIR_UP;
        end else begin
          next_frame = frame_q - 1'b1;
        end
      end
    end else if (Mode_Sig == MODE_LOOP) begin
      next_dir = DIR_UP;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    frame_d   = frame_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    done_d    = 1'b0;
    hold_exit = 1'b0;
`ifdef SPRITE_SEQ_PINGPONG_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start_Sig && !Stop_Sig) begin
          state_d = ST_LOAD;
          row_d   = '0;
          frame_d = '0;
`ifdef SPRITE_SEQ_PINGPONG_EN
          dir_d   = DIR_UP;
`endif
        end
      end
      ST_LOAD: begin
        we_d  = 1'b1;
        wa_d  = row_q;
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = ST_DRAIN;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_HOLD;
        hold_d  = Delay_Ms;
      end
      ST_HOLD: begin
        if (ms_tick && (hold_q != '0)) begin
          hold_d = hold_q - 1'b1;
        end
        // Leave on the tick that would take the count to zero so the hold
        // lasts exactly Delay_Ms*(TICK_DIV+1) cycles.
        hold_exit = (hold_q == '0) || (ms_tick && (hold_q == DELAY_W'(1)));
        if (hold_exit) begin
          if (Stop_Sig) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
            row_d   = '0;
            frame_d = next_frame;
`ifdef SPRITE_SEQ_PINGPONG_EN
            dir_d   = next_dir;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      done_q  <= 1'b0;
`ifdef SPRITE_SEQ_PINGPONG_EN
      dir_q   <= DIR_UP;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      done_q  <= done_d;
`ifdef SPRITE_SEQ_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

endmodule

// File: doc/sprite_anim_sequencer.md
SPRITE_ANIM_SEQUENCER -- requirements
Module: sprite_anim_sequencer

Interface
REQ-001 Parameter FRAMES, 6, number of sprite frames stored in ROM (>=1).
REQ-002 Parameter ROWS, 16, rows per frame (power of two, >=2).
REQ-003 Parameter ROW_W, 16, bits per row word.
REQ-004 Parameter TICK_DIV, 39999, CLK cycles per millisecond tick minus one (40 MHz -> 1 ms).
REQ-005 Parameter DELAY_W, 10, width of the per-frame delay in ms.
REQ-006 CLK  input  1  single clock; all logic on its rising edge.
REQ-007 RSTn  input  1  asynchronous, active-low reset.
REQ-008 Start_Sig  input  1  level; begins playback from frame 0 when idle.
REQ-009 Stop_Sig  input  1  level; requests stop at next frame boundary.
REQ-010 Mode_Sig  input  1  0 = loop, 1 = ping-pong.
REQ-011 Delay_Ms  input  DELAY_W  hold time per frame, ms.
REQ-012 Rom_Addr  output  clog2(FRAMES*ROWS)  synchronous ROM address, frame*ROWS+row.
REQ-013 Rom_Data  input  ROW_W  ROM word, valid exactly 1 cycle after Rom_Addr.
REQ-014 Write_En_Sig  output  1  frame-buffer write strobe.
REQ-015 Write_Addr_Sig  output  clog2(ROWS)  frame-buffer row address.
REQ-016 Write_Data  output  ROW_W  frame-buffer row data.
REQ-017 Frame_Idx  output  clog2(FRAMES) (min 1)  frame currently loaded/displayed.
REQ-018 Busy_Sig  output  1  high in any state except IDLE.
REQ-019 Frame_Done_Sig  output  1  one-cycle pulse when a frame's last row is written.

Function
REQ-020 FSM states IDLE, LOAD, DRAIN, HOLD; IDLE->LOAD on Start_Sig=1 and Stop_Sig=0.
REQ-021 LOAD issues rows 0..ROWS-1 of Frame_Idx on consecutive cycles, one address per cycle, then DRAIN.
REQ-022 Write pipeline: row r address issued cycle n -> Write_En_Sig=1, Write_Addr_Sig=r, Write_Data=Rom_Data at cycle n+1; exactly ROWS writes per frame, no gaps.
REQ-023 DRAIN lasts 1 cycle (last write); Frame_Done_Sig pulses with the last write; then HOLD.
REQ-024 HOLD samples Delay_Ms on entry; counts that many ms ticks; Delay_Ms=0 -> leaves HOLD after 1 cycle.
REQ-025 ms prescaler counts 0..TICK_DIV only in HOLD; cleared on HOLD entry, so first tick is TICK_DIV+1 cycles after entry.
REQ-026 HOLD exit: Stop_Sig=1 (sampled at exit cycle) -> IDLE, Frame_Idx held; else advance frame -> LOAD.
REQ-027 Loop mode: Frame_Idx increments, wraps FRAMES-1 -> 0.
REQ-028 Ping-pong mode: direction reverses at 0 and FRAMES-1 (sequence 0,1,..,F-1,F-2,..,1,0,1..); endpoints not repeated.
REQ-029 FRAMES=1: Frame_Idx stays 0 in both modes; frame reloaded each cycle of play.
REQ-030 Mode_Sig changes take effect at the next advance; switching to loop keeps current index, direction resets to up.
REQ-031 Start_Sig while Busy_Sig=1 ignored; Stop_Sig during LOAD/DRAIN deferred to HOLD exit; Start and Stop both high in IDLE -> stay IDLE.
REQ-032 IDLE->LOAD always restarts at frame 0, direction up.

Reset
REQ-033 RSTn=0 asynchronously forces IDLE, Frame_Idx=0, direction up, counters 0, Rom_Addr=0, Write_En_Sig=0, Write_Addr_Sig=0, Write_Data=0, Busy_Sig=0, Frame_Done_Sig=0.
REQ-034 Reset mid-LOAD aborts the frame; no write occurs in the cycle after RSTn release.

Configuration
REQ-035 Macro SPRITE_SEQ_PINGPONG_EN defined: REQ-028 active.
REQ-036 Macro undefined: Mode_Sig ignored, loop mode only, direction logic not synthesised; ports unchanged.

Structure
REQ-037 Package sprite_seq_pkg holds the FSM state encoding and MODE_LOOP/MODE_PINGPONG constants.
REQ-038 Sub-module ms_tick_gen (params TICK_DIV; ports CLK, RSTn, enable, tick) provides the ms tick.

Verification (bench uses FRAMES=4, ROWS=4, TICK_DIV=9, ROM word = addr*3)
REQ-039 Start pulse, Delay_Ms=2, loop -> writes addr 0..3 data 0,3,6,9 on 4 consecutive cycles; Frame_Done_Sig with 4th; next LOAD 21 cycles after DRAIN; frames 0,1,2,3,0.
REQ-040 Mode_Sig=1, Delay_Ms=0 -> Frame_Idx sequence 0,1,2,3,2,1,0,1; (macro undefined: 0,1,2,3,0,1,2,3).
REQ-041 Stop_Sig raised mid-LOAD of frame 2 -> frame 2 fully written (4 writes), then IDLE, Frame_Idx=2, Busy_Sig=0.
REQ-042 Start_Sig and Stop_Sig both high in IDLE -> no writes, Busy_Sig stays 0; Start while busy -> sequence unaffected.
REQ-043 RSTn low after 2nd write of a frame -> all outputs at reset values immediately; Start after release -> frame 0 row 0 written first.
